// File: rtl/bcd2b_999999.sv
// rtl/bcd2b_999999.sv - six-digit packed-BCD to binary converter, one digit per clock
module bcd2b_999999 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] din,
    output logic        busy,
    output logic        done,
    output logic [23:0] dout,
    output logic        err
);

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t      state_q, state_d;
    logic [23:0] shreg_q, shreg_d;
    logic [23:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        err_latch_q, err_latch_d;
    logic [23:0] dout_q, dout_d;
    logic        err_q, err_d;
    logic        done_q, done_d;

    logic [3:0]  digit;
    logic        digit_bad;
    logic [23:0] acc_next;

    assign digit     = shreg_q[23:20];
    assign digit_bad = (digit > 4'd9);
    // acc*10 + d; six digits of at most 15 each still fit well inside 24 bits
    assign acc_next  = (acc_q << 3) + (acc_q << 1) + {20'd0, digit};

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        err_latch_d = err_latch_q;
        dout_d      = dout_q;
        err_d       = err_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shreg_d     = din;
                    acc_d       = 24'd0;
                    cnt_d       = 3'd0;
                    err_latch_d = 1'b0;
                    state_d     = S_CONV;
                end
            end
            S_CONV: begin
                acc_d       = acc_next;
                shreg_d     = shreg_q << 4;
                err_latch_d = err_latch_q | digit_bad;
                cnt_d       = cnt_q + 3'd1;
                if (cnt_q == 3'd5) begin
                    dout_d  = (err_latch_q | digit_bad) ? 24'd0 : acc_next;
                    err_d   = err_latch_q | digit_bad;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shreg_q     <= 24'd0;
            acc_q       <= 24'd0;
            cnt_q       <= 3'd0;
            err_latch_q <= 1'b0;
            dout_q      <= 24'd0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            err_latch_q <= err_latch_d;
            dout_q      <= dout_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

    assign busy = (state_q == S_CONV);
    assign done = done_q;
    assign dout = dout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd2b_999999.sv
// tb/tb_bcd2b_999999.sv - directed-vector bench for bcd2b_999999
module tb_bcd2b_999999;

    logic        clk;
    logic        rst;
    logic        start;
    logic [23:0] din;
    logic        busy;
    logic        done;
    logic [23:0] dout;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    bcd2b_999999 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .dout  (dout),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Start a conversion at the next edge and follow it to done.
    // inj > 0 pulses start with 999999 on that busy cycle to prove it is ignored.
    task automatic run(input string tag, input logic [23:0] v, input logic [23:0] exp_dout,
                       input logic exp_err, input int inj);
        int lat;
        int busy_cnt;
        int extra_done;
        lat        = 99;
        busy_cnt   = 0;
        extra_done = 0;
        @(negedge clk);
        din   = v;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (inj > 0 && k == inj) begin
                start = 1'b1;
                din   = 24'h999999;
            end else if (inj > 0 && k == inj + 1) begin
                start = 1'b0;
            end
            if (done) begin
                lat = k - 1;
                break;
            end
            if (busy) busy_cnt++;
        end
        check({tag, "_latency"}, lat, 6);
        check({tag, "_busy_cycles"}, busy_cnt, 6);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 0);
        check({tag, "_dout"}, {8'd0, dout}, {8'd0, exp_dout});
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        if (inj > 0) begin
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (done || busy) extra_done++;
            end
            check({tag, "_no_second_conv"}, extra_done, 0);
            check({tag, "_dout_held"}, {8'd0, dout}, {8'd0, exp_dout});
        end else begin
            @(negedge clk);
            check({tag, "_done_one_cycle"}, {31'd0, done}, 0);
        end
    endtask

    initial begin
        int done_idx[$];
        int busy_low;
        int stray;
        rst   = 1'b1;
        start = 1'b0;
        din   = 24'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_done", {31'd0, done}, 0);
        check("reset_dout", {8'd0, dout}, 0);
        check("reset_err", {31'd0, err}, 0);
        rst = 1'b0;

        run("v123456", 24'h123456, 24'h01E240, 1'b0, 0);
        run("v999999", 24'h999999, 24'h0F423F, 1'b0, 0);
        run("v000000", 24'h000000, 24'h000000, 1'b0, 0);
        run("v12A456", 24'h12A456, 24'h000000, 1'b1, 0);
        run("v000009", 24'h000009, 24'h000009, 1'b0, 0);
        run("v000100", 24'h000100, 24'h000064, 1'b0, 3);

        // start held high: a conversion every 7 cycles
        @(negedge clk);
        din      = 24'h000042;
        start    = 1'b1;
        busy_low = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) begin
                done_idx.push_back(k);
                check("b2b_dout", {8'd0, dout}, 32'h2A);
                check("b2b_err", {31'd0, err}, 0);
            end
            if (done_idx.size() >= 1 && done_idx.size() < 3 && !busy) busy_low++;
        end
        start = 1'b0;
        check("b2b_done_count", done_idx.size(), 4);
        if (done_idx.size() >= 3) begin
            check("b2b_gap1", done_idx[1] - done_idx[0], 7);
            check("b2b_gap2", done_idx[2] - done_idx[1], 7);
        end
        check("b2b_busy_low", busy_low, 2);
        repeat (10) @(negedge clk);

        // rst sampled on the third CONV edge aborts the run
        @(negedge clk);
        din   = 24'h555555;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_done", {31'd0, done}, 0);
        check("abort_dout", {8'd0, dout}, 0);
        check("abort_err", {31'd0, err}, 0);
        // start alongside rst is ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        stray = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        check("abort_no_activity", stray, 0);

        run("v000001", 24'h000001, 24'h000001, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd2b_999999.md
# bcd2b_999999

Sequential six-digit packed-BCD to binary converter for the DE2 seven-segment clock path. It converts one BCD digit per clock, most significant digit first, using accumulate-times-ten. It sits between BCD time-set/keypad entry logic and the binary counter/compare logic. A start/done handshake governs it, and it flags any non-decimal nibble.

## Interface
- No parameters; width fixed at 6 digits in, 24-bit binary out (max 999999 = 24'h0F423F).
- clk  in  1  system clock; everything is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request conversion of din; sampled only in IDLE.
- din  in  24  packed BCD, digit 5 in [23:20] down to digit 0 in [3:0].
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse: dout/err valid and updated.
- dout  out  24  binary result; upper 4 bits always 0; held until next done.
- err  out  1  high if the last conversion saw a nibble > 9; held with dout.

## Operation
- States: IDLE, CONV. busy = (state == CONV).
- IDLE with start=1:
  - Capture din into a 24-bit shift register.
  - Clear the accumulator and set the digit counter to 0.
  - Clear the internal error latch.
  - Go to CONV.
- IDLE with start=0: hold all state.
- CONV, each cycle:
  - d = shreg[23:20].
  - acc <= acc*10 + d, computed as (acc<<3)+(acc<<1)+d, 24-bit, no overflow possible.
  - shreg <= shreg<<4.
  - If d > 9, set the error latch; d is still accumulated, but the result is discarded.
  - Increment the counter.
- CONV, counter == 5 (sixth digit):
  - Register the final result in the same edge: dout <= error ? 0 : final acc, and err <= error latch (including this digit's check).
  - Assert done for the next cycle and return to IDLE.
- start while busy is ignored; the captured operand does not change. Changes on din after capture have no effect.
- start in the cycle done is high: state is IDLE, so it is accepted. Back-to-back conversions run every 7 cycles.
- Reset values: state IDLE, busy 0, done 0, dout 24'h0, err 0, accumulator/shift register/counter 0.
- rst asserted mid-conversion aborts it. No done is produced and outputs return to reset values on that edge. A start in the same cycle as rst is ignored.

## Timing
- start sampled high at edge N. busy is high in the cycles after edges N..N+5, and low after N+6.
- Six CONV edges, N+1..N+6. dout, err and done update at edge N+6.
- done is high for exactly the one cycle after edge N+6; latency from start edge to done is 6 clocks.
- dout/err are stable from edge N+6 until the next done or rst. They do not change while busy.
- done never asserts without a preceding accepted start. Exactly one done per accepted start unless aborted by rst.

## Test plan
- Reset, then start with din=24'h123456 → done one cycle after edge 6, dout=24'h01E240, err=0, busy high for exactly 6 cycles.
- din=24'h999999 → dout=24'h0F423F, err=0. Then din=24'h000000 → dout=24'h0, err=0.
- din=24'h12A456 → done on schedule, dout=24'h0, err=1. A following din=24'h000009 → dout=24'h9, err=0.
- start with din=24'h000100; pulse start with din=24'h999999 during busy → single done, dout=24'h000064, no second conversion.
- Hold start high continuously with din=24'h000042 → done every 7 cycles, dout=24'h2A each time, busy low exactly one cycle between runs.
- Assert rst at CONV cycle 3 of din=24'h555555 → busy/done/dout/err 0 next cycle and no done pulse. A new start with 24'h000001 → dout=24'h1 after 6 clocks.
